pc_unit: RTL and testbench

- Parametrised program-counter unit for the datapath.
- Supports:
  - sequential increment by a configurable step
  - conditional PC-relative branch
  - absolute jump
  - call/return through an internal return-address stack (RAS)
  - hold
- Sits between control unit and instruction-memory address port.
- Replaces the fixed increment-or-load PC register.

---
 rtl/pc_pkg.sv | 25 ++
 rtl/ras_stack.sv | 61 ++++++
 rtl/pc_unit.sv | 94 +++++++++
 tb/tb_pc_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_pkg
// Brief    : Operation encoding and helpers shared by the program-counter unit.
// Revision : 1.0
// ============================================================================
package pc_pkg;

  localparam logic [2:0] OP_INC  = 3'd0;
  localparam logic [2:0] OP_BR   = 3'd1;
  localparam logic [2:0] OP_JMP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_HOLD = 3'd5;

  // Ceiling log2; a depth of 1 still yields a 1-bit pointer.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
// Module   : ras_stack
// Brief    : Circular return-address stack; overflow overwrites the oldest entry.
// Revision : 1.0
// ============================================================================
module ras_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             ovf_evt,
  output logic             unf_evt
);

  localparam int            PW      = clog2(DEPTH);
  localparam logic [PW:0]   C_DEPTH = DEPTH[PW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [PW:0]      r_cnt;
  logic [PW-1:0]    w_wr_ptr;
  logic             w_do_pop;

  assign empty    = (r_cnt == '0);
  assign full     = (r_cnt == C_DEPTH);
  assign dout     = r_mem[r_ptr];
  assign w_wr_ptr = r_ptr + 1'b1;
  assign w_do_pop = pop & ~push & ~empty;
  assign ovf_evt  = push & full;
  assign unf_evt  = pop & ~push & empty;

  // A push while full still advances the pointer, so the oldest slot is reused.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (push) begin
      r_ptr <= w_wr_ptr;
      if (!full) r_cnt <= r_cnt + 1'b1;
    end else if (w_do_pop) begin
      r_ptr <= r_ptr - 1'b1;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[w_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Brief    : Program counter with increment, branch, jump, call/return and hold.
// Revision : 1.0
// ============================================================================
module pc_unit
  import pc_pkg::*;
#(
  parameter int                  PC_WIDTH  = 32,
  parameter int                  STEP      = 1,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                clear_n,
  input  logic                en,
  input  logic [2:0]          op,
  input  logic                cond,
  input  logic [PC_WIDTH-1:0] target,
  input  logic                clr_err,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_seq,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_ovf,
  output logic                ras_unf
);

  localparam logic [PC_WIDTH-1:0] C_STEP = PC_WIDTH'(STEP);

  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic [PC_WIDTH-1:0] w_ras_top;
  logic                w_push;
  logic                w_pop;
  logic                w_ovf_evt;
  logic                w_unf_evt;
  logic                r_ovf;
  logic                r_unf;

  assign pc     = r_pc;
  assign pc_seq = r_pc + C_STEP;
  assign w_push = en & (op == OP_CALL);
  assign w_pop  = en & (op == OP_RET);

  ras_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .clear_n (clear_n),
    .push    (w_push),
    .pop     (w_pop),
    .din     (pc_seq),
    .dout    (w_ras_top),
    .empty   (ras_empty),
    .full    (ras_full),
    .ovf_evt (w_ovf_evt),
    .unf_evt (w_unf_evt)
  );

  // The branch offset is two's complement at full width, so a plain add covers both directions.
  always_comb begin
    w_pc_next = r_pc;
    if (en) begin
      case (op)
        OP_INC:  w_pc_next = pc_seq;
        OP_BR:   w_pc_next = cond ? (r_pc + target) : pc_seq;
        OP_JMP:  w_pc_next = target;
        OP_CALL: w_pc_next = target;
        OP_RET:  w_pc_next = ras_empty ? pc_seq : w_ras_top;
        default: w_pc_next = r_pc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_pc  <= RESET_PC;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc  <= w_pc_next;
      r_ovf <= w_ovf_evt | (r_ovf & ~clr_err);
      r_unf <= w_unf_evt | (r_unf & ~clr_err);
    end
  end

  assign ras_ovf = r_ovf;
  assign ras_unf = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Brief    : Scoreboard bench for pc_unit against a queue-based stack model.
// Revision : 1.0
// ============================================================================
module tb_pc_unit;
  import pc_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic        e;
    logic        f;
    logic        o;
    logic        u;
  } obs_t;

  logic        clk = 1'b0;
  logic        clear_n = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  op = OP_HOLD;
  logic        cond = 1'b0;
  logic [31:0] target = '0;
  logic        clr_err = 1'b0;
  logic [31:0] pc, pc_seq;
  logic        ras_empty, ras_full, ras_ovf, ras_unf;

  logic        en4 = 1'b0;
  logic [2:0]  op4 = OP_INC;
  logic        cond4 = 1'b0;
  logic [31:0] target4 = '0;
  logic        clr4 = 1'b0;
  logic [31:0] pc4, pc_seq4;
  logic        e4, f4, o4, u4;

  always #5 clk = ~clk;

  pc_unit #(.PC_WIDTH(32), .STEP(1), .RESET_PC(32'h0), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .clear_n(clear_n), .en(en), .op(op), .cond(cond), .target(target),
    .clr_err(clr_err), .pc(pc), .pc_seq(pc_seq), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  pc_unit #(.PC_WIDTH(32), .STEP(4), .RESET_PC(32'hFFFF_FFF8), .RAS_DEPTH(DEPTH)) dut4 (
    .clk(clk), .clear_n(clear_n), .en(en4), .op(op4), .cond(cond4), .target(target4),
    .clr_err(clr4), .pc(pc4), .pc_seq(pc_seq4), .ras_empty(e4),
    .ras_full(f4), .ras_ovf(o4), .ras_unf(u4)
  );

  obs_t        exp_q[$];
  logic [31:0] q4[$];
  logic [31:0] m_pc;
  logic [31:0] m_stk[$];
  logic        m_ovf, m_unf;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic model_reset();
    m_pc  = 32'h0;
    m_stk = {};
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive one cycle, advance the model, queue the expected post-edge state.
  task automatic drive(input logic d_en, input logic [2:0] d_op, input logic d_cond,
                       input logic [31:0] d_tgt, input logic d_clr);
    logic ov;
    logic un;
    obs_t x;
    ov = 1'b0;
    un = 1'b0;
    en = d_en; op = d_op; cond = d_cond; target = d_tgt; clr_err = d_clr;
    if (d_en) begin
      case (d_op)
        OP_INC:  m_pc = m_pc + 32'd1;
        OP_BR:   m_pc = d_cond ? m_pc + d_tgt : m_pc + 32'd1;
        OP_JMP:  m_pc = d_tgt;
        OP_CALL: begin
          if (m_stk.size() == DEPTH) begin
            void'(m_stk.pop_front());
            ov = 1'b1;
          end
          m_stk.push_back(m_pc + 32'd1);
          m_pc = d_tgt;
        end
        OP_RET: begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin
            m_pc = m_pc + 32'd1;
            un = 1'b1;
          end
        end
        default: ;
      endcase
    end
    m_ovf = ov | (m_ovf & ~d_clr);
    m_unf = un | (m_unf & ~d_clr);
    x.pc = m_pc;
    x.e  = (m_stk.size() == 0);
    x.f  = (m_stk.size() == DEPTH);
    x.o  = m_ovf;
    x.u  = m_unf;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    en = 1'b0; op = OP_HOLD; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0]  ops [5] = '{OP_RET, OP_CALL, OP_INC, OP_INC, OP_INC};
    logic [31:0] tgs [5] = '{32'h0, 32'h2, 32'h0, 32'h0, 32'h0};
    obs_t e, g;
    #1 clear_n = 1'b0;
    #2;
    g = {pc, ras_empty, ras_full, ras_ovf, ras_unf};
    n_chk++;
    if (g !== {32'h0, 4'b1000}) begin
      n_err++;
      $display("FAIL reset_init: got pc=%h e/f/o/u=%b%b%b%b, want pc=0 e/f/o/u=1000", g.pc, g.e, g.f, g.o, g.u);
    end
    n_chk++;
    if (pc_seq !== 32'h1) begin
      n_err++;
      $display("FAIL reset_pc_seq: got %h, want 00000001", pc_seq);
    end
    @(posedge clk); #1;
    clear_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ops[i], 1'b0, tgs[i], 1'b0);
      e = exp_q.pop_front();
      g = {pc, ras_empty, ras_full, ras_ovf, ras_unf};
      n_chk++;
      if (g !== e) begin
        n_err++;
        $display("FAIL pre_reset[%0d]: got pc=%h e/f/o/u=%b%b%b%b, want pc=%h e/f/o/u=%b%b%b%b",
                 i, g.pc, g.e, g.f, g.o, g.u, e.pc, e.e, e.f, e.o, e.u);
      end
    end
    // pc = 5 with a stacked entry and a sticky flag; reset between edges.
    #2 clear_n = 1'b0;
    #1;
    g = {pc, ras_empty, ras_full, ras_ovf, ras_unf};
    n_chk++;
    if (g !== {32'h0, 4'b1000}) begin
      n_err++;
      $display("FAIL reset_mid: got pc=%h e/f/o/u=%b%b%b%b, want pc=0 e/f/o/u=1000", g.pc, g.e, g.f, g.o, g.u);
    end
    #1 clear_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    logic [31:0] w;
    q4.push_back(32'hFFFF_FFFC);
    q4.push_back(32'h0000_0000);
    q4.push_back(32'h0000_0004);
    n_chk++;
    if (pc4 !== 32'hFFFF_FFF8) begin
      n_err++;
      $display("FAIL wrap_start: got %h, want fffffff8", pc4);
    end
    en4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      w = q4.pop_front();
      n_chk++;
      if (pc4 !== w) begin
        n_err++;
        $display("FAIL wrap[%0d]: got %h, want %h", i, pc4, w);
      end
    end
    en4 = 1'b0;
  endtask

  task automatic test_branch();
    logic [2:0]  ops [3] = '{OP_JMP, OP_BR, OP_BR};
    logic        cds [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] tgs [3] = '{32'h100, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
    obs_t e, g;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ops[i], cds[i], tgs[i], 1'b0);
      e = exp_q.pop_front();
      g = {pc, ras_empty, ras_full, ras_ovf, ras_unf};
      n_chk++;
      if (g !== e) begin
        n_err++;
        $display("FAIL branch[%0d]: got pc=%h e/f/o/u=%b%b%b%b, want pc=%h e/f/o/u=%b%b%b%b",
                 i, g.pc, g.e, g.f, g.o, g.u, e.pc, e.e, e.f, e.o, e.u);
      end
    end
  endtask

  task automatic test_call_ret();
    logic [2:0]  ops [5] = '{OP_JMP, OP_CALL, OP_CALL, OP_RET, OP_RET};
    logic [31:0] tgs [5] = '{32'h10, 32'h200, 32'h300, 32'h0, 32'h0};
    obs_t e, g;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ops[i], 1'b0, tgs[i], 1'b0);
      e = exp_q.pop_front();
      g = {pc, ras_empty, ras_full, ras_ovf, ras_unf};
      n_chk++;
      if (g !== e) begin
        n_err++;
        $display("FAIL call_ret[%0d]: got pc=%h e/f/o/u=%b%b%b%b, want pc=%h e/f/o/u=%b%b%b%b",
                 i, g.pc, g.e, g.f, g.o, g.u, e.pc, e.e, e.f, e.o, e.u);
      end
    end
  endtask

  task automatic test_ovf_unf();
    logic [2:0]  ops [15] = '{OP_JMP, OP_CALL, OP_CALL, OP_CALL, OP_CALL, OP_CALL,
                              OP_RET, OP_RET, OP_RET, OP_RET, OP_RET,
                              OP_HOLD, OP_RET, OP_HOLD, OP_INC};
    logic [31:0] tgs [15] = '{32'h0, 32'h10, 32'h20, 32'h30, 32'h40, 32'h50,
                              32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        clr [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    obs_t e, g;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, ops[i], 1'b0, tgs[i], clr[i]);
      e = exp_q.pop_front();
      g = {pc, ras_empty, ras_full, ras_ovf, ras_unf};
      n_chk++;
      if (g !== e) begin
        n_err++;
        $display("FAIL ovf_unf[%0d]: got pc=%h e/f/o/u=%b%b%b%b, want pc=%h e/f/o/u=%b%b%b%b",
                 i, g.pc, g.e, g.f, g.o, g.u, e.pc, e.e, e.f, e.o, e.u);
      end
    end
  endtask

  task automatic test_hold();
    logic        ens [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0]  ops [9] = '{OP_RET, OP_CALL, OP_CALL, OP_CALL, OP_CALL,
                             OP_HOLD, 3'd6, 3'd7, OP_RET};
    logic [31:0] tgs [9] = '{32'h0, 32'h80, 32'h900, 32'h900, 32'h900,
                             32'h900, 32'h900, 32'h900, 32'h0};
    logic        clr [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    obs_t e, g;
    for (int i = 0; i < 9; i++) begin
      drive(ens[i], ops[i], 1'b1, tgs[i], clr[i]);
      e = exp_q.pop_front();
      g = {pc, ras_empty, ras_full, ras_ovf, ras_unf};
      n_chk++;
      if (g !== e) begin
        n_err++;
        $display("FAIL hold[%0d]: got pc=%h e/f/o/u=%b%b%b%b, want pc=%h e/f/o/u=%b%b%b%b",
                 i, g.pc, g.e, g.f, g.o, g.u, e.pc, e.e, e.f, e.o, e.u);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_branch();
    test_call_ret();
    test_ovf_unf();
    test_hold();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
